// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - two-source OLED/segment pin arbiter with drain and blanking hold (optional drain timeout: DISP_ARB_TIMEOUT_EN)
module display_arbiter #(
    parameter logic [15:0] HOLD_CYC      = 16'd1000,
    parameter logic [23:0] DRAIN_TIMEOUT = 24'd2_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       mode_tgl,
    input  logic       busy_1,
    input  logic       busy_2,
    input  logic [3:0] oled_bus_1,
    input  logic [3:0] oled_bus_2,
    input  logic [7:0] seg_sel_1,
    input  logic [7:0] seg_sel_2,
    input  logic [7:0] seg_led_1,
    input  logic [7:0] seg_led_2,
    input  logic [3:0] led_1,
    input  logic [3:0] led_2,
    input  logic [3:0] col_1,
    input  logic [3:0] col_2,
    output logic       oled_rst,
    output logic       oled_dcn,
    output logic       oled_clk,
    output logic       oled_dat,
    output logic [7:0] seg_sel,
    output logic [7:0] seg_led,
    output logic [3:0] led,
    output logic [3:0] col,
    output logic [1:0] choose,
    output logic       src_rst_1,
    output logic       src_rst_2,
    output logic       switching,
    output logic       drain_to
);

    localparam logic [1:0] ST_ACT   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    // Pin bundle order: {oled rst,dcn,clk,dat, seg_sel, seg_led, led, col}
    localparam logic [27:0] BLANK_PINS = {4'b0010, 8'hFF, 8'hFF, 4'h0, 4'hF};

    logic [1:0]  state_q, state_d;
    logic [1:0]  choose_q, choose_d;
    logic [15:0] hold_q, hold_d;
    logic        pend_q, pend_d;
    logic [27:0] pins_q, pins_d;
    logic        drain_exit;
    logic        cur_busy;
    logic [27:0] src1_pins, src2_pins;

    assign src1_pins = {oled_bus_1, seg_sel_1, seg_led_1, led_1, col_1};
    assign src2_pins = {oled_bus_2, seg_sel_2, seg_led_2, led_2, col_2};
    // Only the source currently driving the pins may hold off the switch
    assign cur_busy  = (choose_q == 2'd2) ? busy_2 : busy_1;

`ifdef DISP_ARB_TIMEOUT_EN
    logic [23:0] to_q, to_d;
    logic        dto_q, dto_d;
`endif

    // Next-state logic: ACT -> DRAIN -> BLANK -> ACT, with one-deep toggle pending
    always_comb begin
        state_d    = state_q;
        choose_d   = choose_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        drain_exit = 1'b0;
`ifdef DISP_ARB_TIMEOUT_EN
        to_d       = to_q;
        dto_d      = dto_q;
`endif
        case (state_q)
            ST_ACT: begin
                if (mode_tgl || pend_q) begin
                    state_d = ST_DRAIN;
                    pend_d  = 1'b0;
`ifdef DISP_ARB_TIMEOUT_EN
                    to_d    = 24'd0;
`endif
                end
            end
            ST_DRAIN: begin
                if (mode_tgl) pend_d = 1'b1;
                if (!cur_busy) begin
                    drain_exit = 1'b1;
`ifdef DISP_ARB_TIMEOUT_EN
                end else if (to_q >= DRAIN_TIMEOUT - 24'd1) begin
                    drain_exit = 1'b1;
                    dto_d      = 1'b1;
                end else begin
                    to_d = to_q + 24'd1;
`endif
                end
                if (drain_exit) begin
                    state_d  = ST_BLANK;
                    choose_d = (choose_q == 2'd1) ? 2'd2 : 2'd1;
                    hold_d   = 16'd0;
                end
            end
            ST_BLANK: begin
                if (mode_tgl) pend_d = 1'b1;
                // Saturating compare so the counter can never wrap
                if (hold_q >= HOLD_CYC - 16'd1) state_d = ST_ACT;
                else                             hold_d  = hold_q + 16'd1;
            end
            default: begin
                state_d  = ST_BLANK;
                choose_d = 2'd1;
                hold_d   = 16'd0;
            end
        endcase
        // Pins are registered from the upcoming state so blanking lines up with BLANK exactly
        if (state_d == ST_BLANK) pins_d = BLANK_PINS;
        else                     pins_d = (choose_d == 2'd2) ? src2_pins : src1_pins;
    end

    // State and output registers; reset parks the block blanking toward source 1
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= ST_BLANK;
            choose_q <= 2'd1;
            hold_q   <= 16'd0;
            pend_q   <= 1'b0;
            pins_q   <= BLANK_PINS;
        end else begin
            state_q  <= state_d;
            choose_q <= choose_d;
            hold_q   <= hold_d;
            pend_q   <= pend_d;
            pins_q   <= pins_d;
        end
    end

`ifdef DISP_ARB_TIMEOUT_EN
    // Drain timeout counter and sticky timeout flag
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            to_q  <= 24'd0;
            dto_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            dto_q <= dto_d;
        end
    end
    assign drain_to = dto_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^DRAIN_TIMEOUT;
    assign drain_to       = 1'b0;
`endif

    assign {oled_rst, oled_dcn, oled_clk, oled_dat, seg_sel, seg_led, led, col} = pins_q;
    assign choose    = choose_q;
    assign switching = (state_q != ST_ACT);
    assign src_rst_1 = (state_q == ST_BLANK) && (choose_q == 2'd1);
    assign src_rst_2 = (state_q == ST_BLANK) && (choose_q == 2'd2);

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 16'd1000: blanking/OLED-reset hold length in cycles (≥1).
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 24'd2_000_000: max cycles waiting for the active source to go idle.
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port sys_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mode_tgl  input  1  single-cycle debounced request to swap active source.
REQ-006 SHALL have ports busy_1, busy_2  input  1 each  source OLED transfer in progress.
REQ-007 SHALL have ports oled_bus_1, oled_bus_2  input  4 each  {rst,dcn,clk,dat} from the frequency and duty subsystems.
REQ-008 SHALL have ports seg_sel_1/2, seg_led_1/2  input  8 each; led_1/2, col_1/2  input  4 each.
REQ-009 SHALL have outputs oled_rst, oled_dcn, oled_clk, oled_dat  1 each; seg_sel, seg_led  8; led, col  4: shared pins.
REQ-010 SHALL have outputs choose  2 (2'd1 = source 1, 2'd2 = source 2), src_rst_1, src_rst_2  1, switching  1, drain_to  1.

Function
REQ-011 SHALL implement FSM states ACT, DRAIN, BLANK.
REQ-012 ACT: all shared outputs SHALL be registered copies of the selected source's inputs (1-cycle latency).
REQ-013 ACT + mode_tgl=1 (or pending flag set) SHALL enter DRAIN next cycle; pending cleared on that transition.
REQ-014 DRAIN: outputs keep following the current source; when the current source's busy is sampled 0, SHALL enter BLANK next cycle.
REQ-015 On entry to BLANK, choose SHALL flip (1<->2) in the same cycle.
REQ-016 BLANK SHALL last exactly HOLD_CYC cycles, then go to ACT.
REQ-017 BLANK outputs: oled_rst=0, oled_dcn=0, oled_clk=1, oled_dat=0, seg_sel=8'hFF, seg_led=8'hFF, led=4'h0, col=4'hF.
REQ-018 src_rst_n of the newly selected source (src_rst_1 if choose=1, else src_rst_2) SHALL be 1 throughout BLANK; both 0 otherwise.
REQ-019 switching SHALL be 1 in DRAIN and BLANK, 0 in ACT.
REQ-020 mode_tgl in DRAIN or BLANK SHALL set a one-deep pending flag; further toggles while pending are ignored.
REQ-021 busy of the non-selected source SHALL be ignored in all states.
REQ-022 The hold counter SHALL be cleared on every BLANK entry; it SHALL never wrap.

Reset
REQ-023 sys_rst=1 SHALL force state BLANK, choose=2'd1, hold counter 0, pending 0, drain_to 0, and BLANK output values (REQ-017), with src_rst_1=1, src_rst_2=0.
REQ-024 Reset asserted mid-DRAIN or mid-BLANK SHALL abort the switch; after release the block completes a full HOLD_CYC BLANK on source 1.

Configuration
REQ-025 Macro DISP_ARB_TIMEOUT_EN defined: DRAIN SHALL also exit to BLANK after DRAIN_TIMEOUT cycles without busy=0, and set drain_to=1 (sticky until reset).
REQ-026 Macro DISP_ARB_TIMEOUT_EN undefined: no timeout counter; DRAIN waits indefinitely; drain_to tied 0.

Verification (HOLD_CYC=4, DRAIN_TIMEOUT=8)
REQ-027 Reset released -> switching=1, choose=1, all outputs blanked for 4 cycles, src_rst_1=1; then ACT, oled_bus_1 appears on pins 1 cycle later.
REQ-028 ACT(choose=1), busy_1=0, mode_tgl pulse at cycle T -> DRAIN at T+1, BLANK and choose=2 at T+2, ACT at T+6, src_rst_2=1 for cycles T+2..T+5.
REQ-029 busy_1=1 held 5 cycles after toggle -> DRAIN persists exactly until busy_1 samples 0; seg pins keep source-1 values meanwhile.
REQ-030 Two mode_tgl pulses during BLANK -> exactly one extra switch after return to ACT; final choose=1.
REQ-031 With DISP_ARB_TIMEOUT_EN, busy_1 stuck 1 -> BLANK after 8 DRAIN cycles, drain_to=1 until sys_rst; without macro, DRAIN never exits, drain_to=0.
REQ-032 sys_rst pulsed during BLANK toward source 2 -> choose=1, full 4-cycle BLANK restarts, pending=0.
